// File: rtl/matrix_streamer.sv
// Streams one N x N matrix from a 1-cycle-latency RAM in row- or column-major order
// through a 2-entry first-word-fall-through buffer with last-of-line/last-of-matrix flags.
module matrix_streamer #(
  parameter int W = 16,
  parameter int N = 4,
  localparam int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          col_major,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rd_data,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last_line,
  output logic          m_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] NA = AW'(N);
  localparam logic [IW-1:0] IMAX = IW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [IW-1:0] o, i;
  logic          cm, more;
  logic          rd_line, rd_last;
  logic          pend, pend_line, pend_last;
  logic [W-1:0]  fifo_data [2];
  logic          fifo_line [2];
  logic          fifo_last [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  logic          hs, accept, finish, run_n, issue, mode, more_now;
  logic          cur_line, cur_last;
  logic [IW-1:0] o_cur, i_cur;
  logic [1:0]    cnt_n;
  logic [2:0]    occ_n;
  logic [AW-1:0] addr_cur;

  // Returning read data counts as a buffer entry in its arrival cycle and is
  // bypassed to the head when the buffer is empty, giving start->valid in 2 cycles.
  always_comb begin
    m_valid = (count != '0) || pend;
    if (count != '0) begin
      m_data      = fifo_data[rd_ptr];
      m_last_line = fifo_line[rd_ptr];
      m_last      = fifo_last[rd_ptr];
    end else if (pend) begin
      m_data      = mem_rd_data;
      m_last_line = pend_line;
      m_last      = pend_last;
    end else begin
      m_data      = '0;
      m_last_line = 1'b0;
      m_last      = 1'b0;
    end
    hs       = m_valid && m_ready;
    accept   = (state == IDLE) && start;
    finish   = (state == RUN) && hs && m_last;
    run_n    = accept || ((state == RUN) && !finish);
    cnt_n    = count + {1'b0, pend} - {1'b0, hs};
    occ_n    = {1'b0, cnt_n} + {2'b00, mem_rd_en};
    mode     = accept ? col_major : cm;
    more_now = accept || more;
    o_cur    = accept ? '0 : o;
    i_cur    = accept ? '0 : i;
    issue    = run_n && more_now && (occ_n < 3'd2);
    cur_line = (i_cur == IMAX);
    cur_last = cur_line && (o_cur == IMAX);
    addr_cur = mode ? (AW'(i_cur) * NA + AW'(o_cur))
                    : (AW'(o_cur) * NA + AW'(i_cur));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cm        <= 1'b0;
      more      <= 1'b0;
      o         <= '0;
      i         <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rd_line   <= 1'b0;
      rd_last   <= 1'b0;
      pend      <= 1'b0;
      pend_line <= 1'b0;
      pend_last <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        fifo_data[k] <= '0;
        fifo_line[k] <= 1'b0;
        fifo_last[k] <= 1'b0;
      end
    end else begin
      state     <= run_n ? RUN : IDLE;
      busy      <= run_n;
      done      <= finish;
      mem_rd_en <= issue;
      if (accept)
        cm <= col_major;
      if (issue) begin
        mem_addr <= addr_cur;
        rd_line  <= cur_line;
        rd_last  <= cur_last;
        more     <= !cur_last;
        if (cur_line) begin
          i <= '0;
          o <= o_cur + 1'b1;
        end else begin
          i <= i_cur + 1'b1;
          o <= o_cur;
        end
      end
      pend      <= mem_rd_en;
      pend_line <= rd_line;
      pend_last <= rd_last;
      if (pend) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_line[wr_ptr] <= pend_line;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (hs)
        rd_ptr <= ~rd_ptr;
      count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_matrix_streamer.sv
// Self-checking bench: RAM model plus an expected-stream reference built from matrix order rules.
module tb_matrix_streamer;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);

  logic          clk = 1'b0;
  logic          rst_n, start, col_major, m_ready;
  logic          busy, done, mem_rd_en, m_valid, m_last_line, m_last;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data, m_data;

  always #5 clk = ~clk;

  matrix_streamer #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .col_major(col_major),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last_line(m_last_line), .m_last(m_last)
  );

  logic [W-1:0] ram [NN];
  always @(posedge clk) if (mem_rd_en === 1'b1) mem_rd_data <= ram[mem_addr];

  typedef struct packed {
    logic [W-1:0] d;
    logic         ln;
    logic         ls;
  } el_t;

  el_t         exp_q[$];
  int unsigned addr_q[$];
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, t_start = 0, rd_cnt = 0, hs_cnt = 0, ready_mode = 0;
  bit          busy_exp = 0, done_exp = 0, stalled = 0, full_rate = 0, saw_done = 0;
  el_t         held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Element k of the stream: row-major reads address k; column-major walks down columns.
  task automatic build(input bit cm);
    int unsigned a;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < NN; k++) begin
      a = cm ? (k % N) * N + k / N : k;
      addr_q.push_back(a);
      exp_q.push_back({ram[a], (k % N) == N - 1, k == NN - 1});
    end
  endtask

  task automatic monitor();
    bit hs, acc;
    int unsigned occ;
    el_t cur;
    hs  = (m_valid === 1'b1) && (m_ready === 1'b1);
    cur = {m_data, m_last_line, m_last};
    chk("busy", busy, busy_exp);
    chk("done", done, done_exp);
    if (done === 1'b1) saw_done = 1;
    occ = rd_cnt - hs_cnt;
    chk("occupancy_le2", occ <= 2, 1);
    if (busy_exp && cyc == t_start + 1) chk("rd_latency", mem_rd_en, 1);
    if (busy_exp && cyc == t_start + 2) chk("valid_latency", m_valid, 1);
    if (mem_rd_en === 1'b1) begin
      chk("rd_room", occ < 2, 1);
      if (rd_cnt < addr_q.size()) chk("rd_addr", mem_addr, addr_q[rd_cnt]);
      else chk("extra_rd", mem_rd_en, 0);
      rd_cnt++;
    end
    if (stalled) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_hold", cur, held);
    end
    if (hs) begin
      if (hs_cnt < exp_q.size()) begin
        chk("stream", cur, exp_q[hs_cnt]);
        if (full_rate) chk("hs_cycle", cyc, t_start + 2 + hs_cnt);
      end else begin
        chk("extra_hs", m_valid, 0);
      end
      hs_cnt++;
    end
    stalled  = (m_valid === 1'b1) && (m_ready === 1'b0);
    held     = cur;
    acc      = !busy_exp && (start === 1'b1);
    done_exp = hs && (hs_cnt == NN);
    if (done_exp) busy_exp = 0;
    if (acc) begin
      busy_exp  = 1;
      t_start   = cyc;
      rd_cnt    = 0;
      hs_cnt    = 0;
      full_rate = (ready_mode == 0);
      build(col_major);
    end
  endtask

  task automatic cycle(input bit st, input bit cm);
    @(negedge clk);
    start     = st;
    col_major = cm;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 99) < 30);
      default: m_ready = 1'b0;
    endcase
    if (ready_mode != 0) full_rate = 0;
    cyc++;
    #1;
    monitor();
  endtask

  task automatic run_transfer(input bit cm, input int unsigned mode);
    ready_mode = mode;
    saw_done   = 0;
    cycle(1'b1, cm);
    for (int k = 0; k < 400 && !saw_done; k++) cycle(1'b0, cm);
    chk("done_seen", saw_done, 1);
    chk("all_streamed", hs_cnt, NN);
  endtask

  task automatic apply_reset(input int unsigned low_cycles);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last_line", m_last_line, 0);
    chk("rst_last", m_last, 0);
    for (int k = 0; k < int'(low_cycles); k++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_done", done, 0);
      chk("rst_hold_valid", m_valid, 0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    busy_exp = 0;
    done_exp = 0;
    stalled  = 0;
    rd_cnt   = 0;
    hs_cnt   = 0;
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < NN; k++) ram[k] = W'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < NN; k++) ram[k] = W'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; col_major = 1'b0; m_ready = 1'b1;
    fill_ramp();
    apply_reset(2);

    // Full-rate row-major and column-major streams of a ramp matrix.
    run_transfer(1'b0, 0);
    run_transfer(1'b1, 0);

    // Random contents under 30% ready duty.
    fill_random();
    run_transfer(1'b0, 1);
    run_transfer(1'b1, 1);
    fill_random();
    run_transfer(1'($urandom_range(0, 1)), 1);

    // Ready held low: only two reads may be outstanding.
    fill_ramp();
    ready_mode = 2;
    saw_done   = 0;
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
    chk("stall_reads", rd_cnt, 2);
    chk("stall_m_valid", m_valid, 1);
    chk("stall_m_data", m_data, 0);
    chk("stall_no_rd", mem_rd_en, 0);
    ready_mode = 0;
    for (int k = 0; k < 100 && !saw_done; k++) cycle(1'b0, 1'b0);
    chk("stall_done_seen", saw_done, 1);

    // Reset in the middle of a transfer, then restart from element 0.
    ready_mode = 0;
    saw_done   = 0;
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 50 && hs_cnt < 5; k++) cycle(1'b0, 1'b0);
    chk("pre_reset_hs", hs_cnt, 5);
    apply_reset(2);
    cycle(1'b0, 1'b0);
    chk("no_done_after_abort", saw_done, 0);
    run_transfer(1'b0, 0);

    // Start held through RUN is ignored; the start seen in the done cycle is taken.
    ready_mode = 0;
    saw_done   = 0;
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 100 && !saw_done; k++) cycle(1'b1, 1'b1);
    chk("held_done_seen", saw_done, 1);
    chk("held_accepted", busy_exp, 1);
    saw_done = 0;
    for (int k = 0; k < 100 && !saw_done; k++) cycle(1'b0, 1'b1);
    chk("back_to_back_done", saw_done, 1);
    chk("back_to_back_all", hs_cnt, NN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
